beep_play_ctrl: RTL and testbench
=================================

Name: beep_play_ctrl

Overview:
- Key-driven play controller that sits directly upstream of the melody beeper and drives its `enable` input.
- Debounces two active-low push keys (play, stop).
- Runs a play/stop state machine.
- Times one full pass of the song, then either stops or loops, according to a mode input.
- Gives a status LED and a one-cycle end-of-song pulse.

Parameters:
- DEBOUNCE_MAX, 20'd999_999, debounce hold count (20 ms at 50 MHz); the key level must be stable for DEBOUNCE_MAX+1 cycles.
- PLAY_MAX, 30'd649_999_999, last cycle index of one song pass (13 s at 50 MHz); a pass is PLAY_MAX+1 cycles.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- key_play_n  input  1  raw play key, active low, asynchronous to clk.
- key_stop_n  input  1  raw stop key, active low, asynchronous to clk.
- loop_mode  input  1  1 = restart the pass automatically at its end; 0 = one-shot. Quasi-static.
- enable  output  1  enable to the melody beeper, registered.
- led_play  output  1  high while in PLAY or RESTART, registered.
- song_done  output  1  one-cycle pulse at the end of a one-shot pass, registered.

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - During reset: synchronizer and debounced-level flops = 1, debounce counters = 0, play_timer = 0, state = IDLE.
  - Output reset values: enable = 0, led_play = 0, song_done = 0.
- Synchronizer: each key passes through a 2-FF synchronizer.
- Debounce (per key):
  - If sync == stable: counter <= 0.
  - Else if counter == DEBOUNCE_MAX: stable <= sync and counter <= 0.
  - Else: counter increments.
  - A glitch shorter than DEBOUNCE_MAX+1 cycles never changes stable.
- Press pulse:
  - Asserted for exactly one cycle on the cycle after stable goes 1->0.
  - No pulse on release.
  - A held key gives one pulse only.
- FSM states: IDLE, PLAY, RESTART.
  - IDLE:
    - enable = 0.
    - play press -> PLAY, play_timer <= 0.
    - stop press is ignored.
  - PLAY:
    - enable = 1; play_timer increments every cycle.
    - Priority order: stop press > play press > timer end.
    - stop press -> IDLE.
    - play press -> RESTART.
    - Timer end (play_timer == PLAY_MAX) with loop_mode = 1 -> stay in PLAY, play_timer <= 0; enable stays 1 with no gap.
    - Timer end with loop_mode = 0 -> IDLE, song_done = 1 for one cycle.
  - RESTART:
    - enable = 0 for exactly one cycle; this forces the beeper's note index back to 0.
    - Next state is PLAY with play_timer = 0.
    - A stop press in this cycle -> IDLE instead.
- Simultaneous press of both keys in the same cycle: stop wins, whatever the state.
- Output timing: outputs are registered from the next state, so enable changes on the clock edge where the state changes. Press-to-enable latency is exactly 1 cycle after the press pulse.
- play_timer:
  - 30 bits wide; never exceeds PLAY_MAX.
  - Held at 0 outside PLAY.
- Reset mid-operation: asynchronous return to the reset values above. The key press in progress is discarded, and a fresh press is needed after reset release.
- song_done is never asserted in loop mode, on a stop press, or on a restart.

Test Plan (all scenarios use DEBOUNCE_MAX=3, PLAY_MAX=20):
1. Reset, then hold key_play_n low for 10 cycles -> exactly one press pulse; enable rises 2+4+1+1 cycles after the key falls; led_play = 1.
2. Pulse key_play_n low for 3 cycles (bounce) -> no press pulse, enable stays 0. Then apply 5 alternating low/high cycles followed by a stable low -> a single press.
3. Play with loop_mode=0 -> enable high for exactly 21 cycles, then 0; song_done high for 1 cycle on the cycle enable falls; state IDLE.
4. Play with loop_mode=1 for 70 cycles -> enable continuously 1 across the wrap; song_done never asserted.
5. During PLAY (timer = 8), press play -> enable 0 for exactly 1 cycle, then 1 with timer restarted at 0; a total of 21 further enable cycles in one-shot mode.
6. During PLAY, press stop and play in the same cycle -> IDLE, enable 0, song_done 0. Then assert rst_n low mid-PLAY -> enable, led_play and song_done go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/beep_play_ctrl.sv
// beep_play_ctrl: key-driven play controller that drives the melody beeper's enable.
// Two active-low keys are synchronized and debounced, and each press becomes a
// one-cycle pulse. An IDLE/PLAY/RESTART FSM times one song pass, then either
// stops or loops according to loop_mode.
// Key vectors below use bit 0 = play key and bit 1 = stop key.
module beep_play_ctrl #(
  parameter logic [19:0] DEBOUNCE_MAX = 20'd999_999,
  parameter logic [29:0] PLAY_MAX     = 30'd649_999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_play_n,
  input  logic key_stop_n,
  input  logic loop_mode,
  output logic enable,
  output logic led_play,
  output logic song_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_RESTART
  } state_e;

  logic [1:0]  meta_q, meta_d;
  logic [1:0]  sync_q, sync_d;
  logic [1:0]  stable_q, stable_d;
  logic [1:0]  prev_q, prev_d;
  logic [1:0]  press_q, press_d;
  logic [19:0] cnt_q [2];
  logic [19:0] cnt_d [2];

  state_e      state_q, state_d;
  logic [29:0] timer_q, timer_d;
  logic        enable_q, enable_d;
  logic        led_q, led_d;
  logic        done_q, done_d;

  logic        play_press;
  logic        stop_press;

  // Synchronizer, debounce and press-edge detection for both keys.
  always_comb begin
    meta_d   = {key_stop_n, key_play_n};
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEBOUNCE_MAX) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 20'd1;
      end
    end
    prev_d  = stable_q;
    press_d = prev_q & ~stable_q;
  end

  // Key-path registers; idle level of each key is high (released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= '1;
      sync_q   <= '1;
      stable_q <= '1;
      prev_q   <= '1;
      press_q  <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign play_press = press_q[0];
  assign stop_press = press_q[1];

  // Next-state, pass timer and registered-output decode; stop press always wins.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!stop_press && play_press) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (stop_press) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (play_press) begin
          state_d = S_RESTART;
          timer_d = '0;
        end else if (timer_q == PLAY_MAX) begin
          timer_d = '0;
          if (!loop_mode) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + 30'd1;
        end
      end
      S_RESTART: begin
        timer_d = '0;
        state_d = stop_press ? S_IDLE : S_PLAY;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
    // Outputs follow the next state so enable moves on the same edge as the state.
    enable_d = (state_d == S_PLAY);
    led_d    = (state_d != S_IDLE);
  end

  // FSM state, timer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      enable_q <= 1'b0;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      enable_q <= enable_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  assign enable    = enable_q;
  assign led_play  = led_q;
  assign song_done = done_q;

endmodule

// File: tb/tb_beep_play_ctrl.sv
// Testbench for beep_play_ctrl with small debounce and pass lengths.
// A queue-based reference model predicts the outputs every cycle, and
// table rows and directed sequences check against fixed expected values.
module tb_beep_play_ctrl;

  localparam int DM = 3;
  localparam int PM = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic kp = 1'b1;
  logic ks = 1'b1;
  logic lm = 1'b0;
  logic en, led, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beep_play_ctrl #(
    .DEBOUNCE_MAX(20'd3),
    .PLAY_MAX    (30'd20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_play_n(kp),
    .key_stop_n(ks),
    .loop_mode (lm),
    .enable    (en),
    .led_play  (led),
    .song_done (done)
  );

  // ---------------- reference model ----------------
  // A key level reaches the debouncer two edges after it is sampled.
  // Debounced level flips once the sync level has differed for DM+1 edges.
  // A fall of the debounced level reaches the FSM two edges later.
  logic m_sq_p[$];
  logic m_sq_s[$];
  logic m_pq_p[$];
  logic m_pq_s[$];
  logic m_st_p, m_st_s;
  int   m_run_p, m_run_s;
  int   m_mode;   // 0 idle, 1 playing, 2 restart gap
  int   m_el;     // cycles elapsed in the current pass
  logic m_done;

  task automatic model_reset();
    m_sq_p = {1'b1, 1'b1};
    m_sq_s = {1'b1, 1'b1};
    m_pq_p = {1'b0, 1'b0};
    m_pq_s = {1'b0, 1'b0};
    m_st_p = 1'b1;
    m_st_s = 1'b1;
    m_run_p = 0;
    m_run_s = 0;
    m_mode = 0;
    m_el = 0;
    m_done = 1'b0;
  endtask

  task automatic debounce(input logic sy, inout logic st, inout int run, output logic fell);
    fell = 1'b0;
    if (sy != st) begin
      run++;
      if (run == DM + 1) begin
        fell = st;
        st = sy;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_edge(input logic p, input logic s, input logic l);
    logic sy_p, sy_s, pr_p, pr_s, f_p, f_s;
    sy_p = m_sq_p.pop_front();
    m_sq_p.push_back(p);
    sy_s = m_sq_s.pop_front();
    m_sq_s.push_back(s);
    pr_p = m_pq_p.pop_front();
    pr_s = m_pq_s.pop_front();
    debounce(sy_p, m_st_p, m_run_p, f_p);
    debounce(sy_s, m_st_s, m_run_s, f_s);
    m_pq_p.push_back(f_p);
    m_pq_s.push_back(f_s);
    m_done = 1'b0;
    if (pr_s) begin
      m_mode = 0;
      m_el = 0;
    end else if (pr_p) begin
      m_mode = (m_mode == 1) ? 2 : 1;
      m_el = 0;
    end else if (m_mode == 2) begin
      m_mode = 1;
      m_el = 0;
    end else if (m_mode == 1) begin
      if (m_el == PM) begin
        m_el = 0;
        if (!l) begin
          m_mode = 0;
          m_done = 1'b1;
        end
      end else begin
        m_el++;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_enable", en, (m_mode == 1));
    chk("model_led_play", led, (m_mode != 0));
    chk("model_song_done", done, m_done);
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample 1 unit later.
  task automatic step(input logic p, input logic s, input logic l);
    @(negedge clk);
    kp = p;
    ks = s;
    lm = l;
    @(posedge clk);
    if (rst_n) model_edge(p, s, l);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    kp = 1'b1;
    ks = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_enable", en, 1'b0);
    chk("reset_led_play", led, 1'b0);
    chk("reset_song_done", done, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic p;
    logic s;
    logic l;
    int   n;
    logic e_en;
    logic e_led;
    logic e_done;
  } vec_t;

  vec_t tbl[12];
  logic en_rec[0:45];
  logic done_rec[0:45];

  initial begin
    int first, saw, rises, highs, dones, gaps, fall_done;
    logic prev_en;
    int hold_p, hold_s;
    logic cur_p, cur_s, cur_l;

    tbl[0]  = '{1'b1, 1'b1, 1'b0,  5, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0,  5, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0,  8, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0,  8, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 25, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1,  8, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 40, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1,  8, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0,  8, 1'b0, 1'b0, 1'b0};

    model_reset();
    do_reset();

    // Table rows: hold inputs for n cycles, then compare with fixed values.
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < tbl[r].n; c++) step(tbl[r].p, tbl[r].s, tbl[r].l);
      chk($sformatf("tbl%0d_enable", r), en, tbl[r].e_en);
      chk($sformatf("tbl%0d_led_play", r), led, tbl[r].e_led);
      chk($sformatf("tbl%0d_song_done", r), done, tbl[r].e_done);
    end

    // Held key: enable rises on edge 8 after the fall, single press only.
    do_reset();
    first = -1;
    rises = 0;
    prev_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (en && first < 0) first = i;
      if (en && !prev_en) rises++;
      prev_en = en;
    end
    chk_int("held_key_latency", first, 8);
    chk_int("held_key_rises", rises, 1);
    chk("held_key_led", led, 1'b1);
    repeat (8) step(1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b1, 1'b0);
    chk("stop_to_idle", en, 1'b0);

    // Bounce: short glitch, then alternating levels, then a stable low.
    do_reset();
    saw = 0;
    repeat (3) begin step(1'b0, 1'b1, 1'b0); if (en) saw++; end
    repeat (10) begin step(1'b1, 1'b1, 1'b0); if (en) saw++; end
    chk_int("glitch_no_enable", saw, 0);
    rises = 0;
    prev_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(((i % 2) == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      if (en && !prev_en) rises++;
      prev_en = en;
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (en && !prev_en) rises++;
      prev_en = en;
    end
    chk_int("bounce_single_press", rises, 1);
    chk("bounce_enable_high", en, 1'b1);
    repeat (8) step(1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b1, 1'b0);

    // One-shot pass: 21 enable cycles, song_done on the falling cycle.
    do_reset();
    highs = 0;
    dones = 0;
    fall_done = 0;
    prev_en = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step((i <= 4) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      if (en) highs++;
      if (done) dones++;
      if (prev_en && !en && done) fall_done++;
      prev_en = en;
    end
    chk_int("oneshot_enable_cycles", highs, PM + 1);
    chk_int("oneshot_done_pulses", dones, 1);
    chk_int("oneshot_done_at_fall", fall_done, 1);
    chk("oneshot_led_idle", led, 1'b0);

    // Loop mode: no gap across wraps, no song_done.
    do_reset();
    first = -1;
    gaps = 0;
    dones = 0;
    for (int i = 1; i <= 80; i++) begin
      step((i <= 4) ? 1'b0 : 1'b1, 1'b1, 1'b1);
      if (en && first < 0) first = i;
      if (first > 0 && !en) gaps++;
      if (done) dones++;
    end
    chk_int("loop_first_enable", first, 8);
    chk_int("loop_enable_gaps", gaps, 0);
    chk_int("loop_done_pulses", dones, 0);
    repeat (8) step(1'b1, 1'b0, 1'b1);
    repeat (8) step(1'b1, 1'b1, 1'b0);
    chk("loop_stop_enable", en, 1'b0);

    // Restart mid-pass: one-cycle gap, then a fresh 21-cycle pass.
    do_reset();
    for (int i = 1; i <= 45; i++) begin
      step(((i <= 4) || (i >= 9 && i <= 14)) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      en_rec[i] = en;
      done_rec[i] = done;
    end
    highs = 0;
    for (int i = 17; i <= 45; i++) if (en_rec[i]) highs++;
    chk("restart_before_gap", en_rec[15], 1'b1);
    chk("restart_gap", en_rec[16], 1'b0);
    chk("restart_gap_no_done", done_rec[16], 1'b0);
    chk("restart_after_gap", en_rec[17], 1'b1);
    chk("restart_last_enable", en_rec[37], 1'b1);
    chk("restart_end_enable", en_rec[38], 1'b0);
    chk("restart_end_done", done_rec[38], 1'b1);
    chk_int("restart_enable_cycles", highs, PM + 1);

    // Both keys together during PLAY, then asynchronous reset mid-PLAY.
    do_reset();
    repeat (4) step(1'b0, 1'b1, 1'b0);
    repeat (8) step(1'b1, 1'b1, 1'b0);
    chk("both_pre_play", en, 1'b1);
    dones = 0;
    repeat (10) begin step(1'b0, 1'b0, 1'b0); if (done) dones++; end
    chk("both_enable", en, 1'b0);
    chk("both_led", led, 1'b0);
    chk_int("both_no_done", dones, 0);
    repeat (8) step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b1, 1'b1, 1'b0);
    chk("async_pre_enable", en, 1'b1);
    chk("async_pre_led", led, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_enable", en, 1'b0);
    chk("async_led_play", led, 1'b0);
    chk("async_song_done", done, 1'b0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) step(1'b1, 1'b1, 1'b0);
    chk("after_reset_idle", en, 1'b0);

    // Random key activity checked cycle by cycle against the model.
    do_reset();
    hold_p = 0;
    hold_s = 0;
    cur_p = 1'b1;
    cur_s = 1'b1;
    cur_l = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (hold_p == 0) begin
        cur_p = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
        hold_p = $urandom_range(1, 12);
      end
      if (hold_s == 0) begin
        cur_s = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
        hold_s = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 99) == 0) cur_l = ~cur_l;
      hold_p--;
      hold_s--;
      step(cur_p, cur_s, cur_l);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
